// File: rtl/pwadder_pkg.sv
// -----------------------------------------------------------------------------
// pwadder_pkg
// Shared definitions for the brute-force password incrementer.
//   - Charset bounds (CHAR_MIN..CHAR_MAX) and the maximum password length.
//   - Widths of the password bus and the length field.
//   - FSM state encoding.
//   - char_lsb(): maps a character index to the LSB position of that
//     character on the 160-bit bus (character 0 sits in the top byte).
// No ports.
// -----------------------------------------------------------------------------
package pwadder_pkg;

    localparam int         MAX_LEN  = 20;
    localparam logic [7:0] CHAR_MIN = 8'h20;
    localparam logic [7:0] CHAR_MAX = 8'h7E;

    localparam int PW_W  = 8 * MAX_LEN;
    localparam int LEN_W = 5;

    // Index of the last character. A carry out of this position is an overflow.
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);
    // Longest length accepted. Larger requested lengths are clamped to this.
    localparam logic [LEN_W-1:0] LEN_CAP  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CARRY = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Character i occupies bits [PW_W-1-8i -: 8], so its LSB is PW_W-8-8i.
    // Indices past the last character are folded onto the last one so that
    // the part-select stays in range. The FSM never uses such an index.
    function automatic logic [7:0] char_lsb(input logic [LEN_W-1:0] idx);
        logic [LEN_W-1:0] safe_idx;
        safe_idx = (idx > LAST_IDX) ? LAST_IDX : idx;
        return 8'(PW_W - 8) - {safe_idx, 3'b000};
    endfunction

endpackage

// File: rtl/pwadder_char_inc.sv
// -----------------------------------------------------------------------------
// pwadder_char_inc
// Combinational single-character odometer step over the charset
// CHAR_MIN..CHAR_MAX.
// Ports:
//   char_i    in  8  current character
//   append_i  in  1  position is one past the current length (new digit)
//   char_o    out 8  next character value
//   carry_o   out 1  character wrapped and the next position must advance
// -----------------------------------------------------------------------------
module pwadder_char_inc
    import pwadder_pkg::*;
#(
    parameter logic [7:0] CHAR_MIN = pwadder_pkg::CHAR_MIN,
    parameter logic [7:0] CHAR_MAX = pwadder_pkg::CHAR_MAX
) (
    input  logic [7:0] char_i,
    input  logic       append_i,
    output logic [7:0] char_o,
    output logic       carry_o
);

    always_comb begin
        char_o  = char_i;
        carry_o = 1'b0;
        if (append_i) begin
            // A new digit starts at the lowest charset value.
            char_o = CHAR_MIN;
        end else if (char_i >= CHAR_MAX) begin
            // Wrap and carry into the next digit. Values above the charset
            // are treated as the top of the charset.
            char_o  = CHAR_MIN;
            carry_o = 1'b1;
        end else if (char_i < CHAR_MIN) begin
            // Below the charset: snap to the first valid value, no carry.
            char_o = CHAR_MIN;
        end else begin
            char_o = char_i + 8'd1;
        end
    end

endmodule

// File: rtl/pwadder_core.sv
// -----------------------------------------------------------------------------
// pwadder_core
// Produces the next password in odometer order over printable ASCII
// (0x20..0x7E). Character 0 is the least-significant digit. One character
// is processed per clock. A carry out of the last character of a full-length
// password wraps the whole password to all 0x20 with length 0.
//
// Optional build macro: PWADDER_OVERFLOW_EN adds the `overflow` output,
// which flags that the last result was such a wrap.
//
// Ports:
//   clk           in  1    rising-edge clock
//   rst           in  1    synchronous active-high reset
//   in_password   in  160  input password, char i at bits [159-8i -: 8]
//   in_length     in  5    valid characters, clamped to MAX_LEN
//   trigger       in  1    start request, rising edge starts an increment
//   out_password  out 160  result password, same layout as in_password
//   out_length    out 5    result length
//   completed     out 1    result on the outputs is final
//   overflow      out 1    (PWADDER_OVERFLOW_EN only) last result wrapped
//   state_dbg     out 2    current FSM state (state_e encoding)
//
// Handshake: a request starts on the clock edge where trigger is 1 and was 0
// on the previous edge, while the FSM is in IDLE or DONE. completed drops on
// that edge and rises on the edge that writes the final character. The
// outputs then hold until the next start edge. Trigger edges seen during
// CARRY are dropped, and a held-high trigger never restarts.
// -----------------------------------------------------------------------------
module pwadder_core #(
    parameter int         MAX_LEN  = pwadder_pkg::MAX_LEN,
    parameter logic [7:0] CHAR_MIN = pwadder_pkg::CHAR_MIN,
    parameter logic [7:0] CHAR_MAX = pwadder_pkg::CHAR_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*MAX_LEN-1:0] in_password,
    input  logic [4:0]           in_length,
    input  logic                 trigger,
    output logic [8*MAX_LEN-1:0] out_password,
    output logic [4:0]           out_length,
    output logic                 completed,
`ifdef PWADDER_OVERFLOW_EN
    output logic                 overflow,
`endif
    output logic [1:0]           state_dbg
);

    import pwadder_pkg::*;

    state_e                 state_q;
    logic [8*MAX_LEN-1:0]   work_q;
    logic [4:0]             len_q;
    logic [4:0]             idx_q;
    logic                   completed_q;
    logic                   trig_q;
`ifdef PWADDER_OVERFLOW_EN
    logic                   overflow_q;
`endif

    logic       start_d;
    logic [4:0] len_clamp_d;
    logic [7:0] idx_lsb;
    logic [7:0] cur_char;
    logic [7:0] nxt_char_d;
    logic       append_d;
    logic       carry_d;
    logic       wrap_all_d;

    // Rising edge of the level trigger against its registered history.
    assign start_d     = trigger & ~trig_q;
    assign len_clamp_d = (in_length > LEN_CAP) ? LEN_CAP : in_length;

    assign idx_lsb  = char_lsb(idx_q);
    assign cur_char = work_q[idx_lsb +: 8];

    // Index has walked past the last valid character: extend by one digit.
    assign append_d = (idx_q == len_q);

    pwadder_char_inc #(
        .CHAR_MIN (CHAR_MIN),
        .CHAR_MAX (CHAR_MAX)
    ) u_char_inc (
        .char_i   (cur_char),
        .append_i (append_d),
        .char_o   (nxt_char_d),
        .carry_o  (carry_d)
    );

    // A carry can only leave the last index when the length is full, since
    // idx < len holds whenever carry_d is set.
    assign wrap_all_d = carry_d && (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= {MAX_LEN{CHAR_MIN}};
            len_q       <= 5'd0;
            idx_q       <= 5'd0;
            completed_q <= 1'b0;
            trig_q      <= 1'b0;
`ifdef PWADDER_OVERFLOW_EN
            overflow_q  <= 1'b0;
`endif
        end else begin
            trig_q <= trigger;
            case (state_q)
                IDLE, DONE: begin
                    if (start_d) begin
                        state_q     <= CARRY;
                        work_q      <= in_password;
                        len_q       <= len_clamp_d;
                        idx_q       <= 5'd0;
                        completed_q <= 1'b0;
`ifdef PWADDER_OVERFLOW_EN
                        overflow_q  <= 1'b0;
`endif
                    end
                end
                CARRY: begin
                    if (wrap_all_d) begin
                        // Full-length carry out: restart the odometer at the
                        // empty password.
                        state_q     <= DONE;
                        work_q      <= {MAX_LEN{CHAR_MIN}};
                        len_q       <= 5'd0;
                        completed_q <= 1'b1;
`ifdef PWADDER_OVERFLOW_EN
                        overflow_q  <= 1'b1;
`endif
                    end else begin
                        work_q[idx_lsb +: 8] <= nxt_char_d;
                        if (carry_d) begin
                            idx_q <= idx_q + 5'd1;
                        end else begin
                            state_q     <= DONE;
                            completed_q <= 1'b1;
                            if (append_d) begin
                                len_q <= len_q + 5'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_password = work_q;
    assign out_length   = len_q;
    assign completed    = completed_q;
`ifdef PWADDER_OVERFLOW_EN
    assign overflow     = overflow_q;
`endif
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pwadder_core.sv
// -----------------------------------------------------------------------------
// tb_pwadder_core
// Directed bench for pwadder_core. Inputs change on the falling edge and
// outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pwadder_core;

    logic         clk;
    logic         rst;
    logic [159:0] in_password;
    logic [4:0]   in_length;
    logic         trigger;
    logic [159:0] out_password;
    logic [4:0]   out_length;
    logic         completed;
`ifdef PWADDER_OVERFLOW_EN
    logic         overflow;
`endif
    logic [1:0]   state_dbg;

    int checks;
    int errors;

    pwadder_core dut (
        .clk          (clk),
        .rst          (rst),
        .in_password  (in_password),
        .in_length    (in_length),
        .trigger      (trigger),
        .out_password (out_password),
        .out_length   (out_length),
        .completed    (completed),
`ifdef PWADDER_OVERFLOW_EN
        .overflow     (overflow),
`endif
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Raise trigger, wait for the start edge N, then count edges until
    // completed is seen (bounded). lat = number of edges after N.
    // Trigger stays high for `hold` more edges after completion.
    task automatic run_req(input logic [159:0] pw, input logic [4:0] len,
                           input int hold, output int lat,
                           output logic done_at_start);
        @(negedge clk);
        in_password = pw;
        in_length   = len;
        trigger     = 1'b1;
        @(posedge clk);
        #1;
        done_at_start = completed;
        lat = 0;
        while (!completed && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        trigger = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        trigger = 1'b0;
        in_password = '0;
        in_length = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (completed !== 1'b0) begin
            errors++; $display("FAIL reset_completed: got %b expected 0", completed);
        end
        checks++;
        if (out_length !== 5'd0) begin
            errors++; $display("FAIL reset_length: got %0d expected 0", out_length);
        end
        checks++;
        if (out_password !== {20{8'h20}}) begin
            errors++; $display("FAIL reset_password: got %h expected %h", out_password, {20{8'h20}});
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (completed !== 1'b0) begin
            errors++; $display("FAIL idle_no_start: got %b expected 0", completed);
        end
    endtask

    task automatic test_empty_append();
        int lat; logic d0;
        run_req({20{8'h20}}, 5'd0, 0, lat, d0);
        checks++;
        if (completed !== 1'b1 || lat !== 1) begin
            errors++; $display("FAIL empty_latency: got completed=%b lat=%0d expected 1 lat=1", completed, lat);
        end
        checks++;
        if (out_password[159:152] !== 8'h20 || out_length !== 5'd1) begin
            errors++; $display("FAIL empty_result: got char0=%h len=%0d expected 20 len=1", out_password[159:152], out_length);
        end
    endtask

    task automatic test_simple_inc();
        int lat; logic d0;
        logic [159:0] pw;
        logic [159:0] exp;
        pw = {20{8'h20}}; pw[159:152] = 8'h41;
        exp = {20{8'h20}}; exp[159:152] = 8'h42;
        run_req(pw, 5'd1, 0, lat, d0);
        checks++;
        if (d0 !== 1'b0) begin
            errors++; $display("FAIL inc_clear_at_start: got %b expected 0", d0);
        end
        checks++;
        if (out_password !== exp || out_length !== 5'd1 || lat !== 1) begin
            errors++; $display("FAIL inc_A: got %h len=%0d lat=%0d expected %h len=1 lat=1", out_password, out_length, lat, exp);
        end
        // below-charset character snaps to 0x20 without carry
        pw = {20{8'h33}}; pw[159:152] = 8'h10;
        exp = {20{8'h33}}; exp[159:152] = 8'h20;
        run_req(pw, 5'd1, 0, lat, d0);
        checks++;
        if (out_password !== exp || out_length !== 5'd1 || lat !== 1) begin
            errors++; $display("FAIL inc_below_min: got %h len=%0d lat=%0d expected %h len=1 lat=1", out_password, out_length, lat, exp);
        end
    endtask

    task automatic test_carry();
        int lat; logic d0;
        logic [159:0] pw;
        logic [159:0] exp;
        // {7E,7E} length 2, tail 0x55: two wraps then an appended digit
        pw = {20{8'h55}}; pw[159:152] = 8'h7E; pw[151:144] = 8'h7E;
        exp = {20{8'h55}}; exp[159:152] = 8'h20; exp[151:144] = 8'h20; exp[143:136] = 8'h20;
        run_req(pw, 5'd2, 0, lat, d0);
        checks++;
        if (out_password !== exp || out_length !== 5'd3 || lat !== 3) begin
            errors++; $display("FAIL carry_append: got %h len=%0d lat=%0d expected %h len=3 lat=3", out_password, out_length, lat, exp);
        end
        // {7E,41} length 2: one wrap, then the next digit increments
        pw = {20{8'h20}}; pw[159:152] = 8'h7E; pw[151:144] = 8'h41;
        exp = {20{8'h20}}; exp[151:144] = 8'h42;
        run_req(pw, 5'd2, 0, lat, d0);
        checks++;
        if (out_password !== exp || out_length !== 5'd2 || lat !== 2) begin
            errors++; $display("FAIL carry_mid: got %h len=%0d lat=%0d expected %h len=2 lat=2", out_password, out_length, lat, exp);
        end
    endtask

    task automatic test_overflow();
        int lat; logic d0;
        run_req({20{8'h7E}}, 5'd20, 0, lat, d0);
        checks++;
        if (out_password !== {20{8'h20}} || out_length !== 5'd0 || lat !== 20) begin
            errors++; $display("FAIL overflow_wrap: got %h len=%0d lat=%0d expected all 20 len=0 lat=20", out_password, out_length, lat);
        end
`ifdef PWADDER_OVERFLOW_EN
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_flag: got %b expected 1", overflow);
        end
`endif
    endtask

    task automatic test_length_clamp();
        int lat; logic d0;
        logic [159:0] exp;
        exp = {20{8'h7D}}; exp[159:152] = 8'h7E;
        run_req({20{8'h7D}}, 5'd25, 0, lat, d0);
        checks++;
        if (out_password !== exp || out_length !== 5'd20 || lat !== 1) begin
            errors++; $display("FAIL clamp_len25: got %h len=%0d lat=%0d expected %h len=20 lat=1", out_password, out_length, lat, exp);
        end
`ifdef PWADDER_OVERFLOW_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL overflow_cleared: got %b expected 0", overflow);
        end
`endif
    endtask

    task automatic test_trigger_held();
        int lat; logic d0;
        logic [159:0] pw;
        logic [159:0] exp;
        pw = {20{8'h20}}; pw[159:152] = 8'h41;
        exp = {20{8'h20}}; exp[159:152] = 8'h42;
        run_req(pw, 5'd1, 8, lat, d0);
        checks++;
        if (out_password !== exp || out_length !== 5'd1 || completed !== 1'b1 || lat !== 1) begin
            errors++; $display("FAIL held_single_inc: got %h len=%0d done=%b lat=%0d expected %h len=1 done=1 lat=1", out_password, out_length, completed, lat, exp);
        end
    endtask

    task automatic test_edge_in_carry();
        int lat;
        @(negedge clk);
        in_password = {20{8'h7E}};
        in_length   = 5'd20;
        trigger     = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk); trigger = 1'b0;
        @(posedge clk); lat++;
        @(negedge clk); trigger = 1'b1;
        @(posedge clk); #1; lat++;
        while (!completed && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (out_password !== {20{8'h20}} || out_length !== 5'd0 || lat !== 20) begin
            errors++; $display("FAIL carry_edge_ignored: got %h len=%0d lat=%0d expected all 20 len=0 lat=20", out_password, out_length, lat);
        end
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic test_reset_mid_carry();
        @(negedge clk);
        in_password = {20{8'h7E}};
        in_length   = 5'd20;
        trigger     = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        trigger = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (completed !== 1'b0 || out_length !== 5'd0 || out_password !== {20{8'h20}} || state_dbg !== 2'd0) begin
            errors++; $display("FAIL reset_mid_carry: got done=%b len=%0d pw=%h st=%0d expected 0 0 all20 0", completed, out_length, out_password, state_dbg);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (completed !== 1'b0 || state_dbg !== 2'd0) begin
            errors++; $display("FAIL reset_stays_idle: got done=%b st=%0d expected 0 0", completed, state_dbg);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic d0;
        logic [159:0] pw;
        logic [159:0] exp;
        pw = {20{8'h61}}; pw[159:152] = 8'h7E;
        exp = {20{8'h61}}; exp[159:152] = 8'h20; exp[151:144] = 8'h20;
        run_req(pw, 5'd1, 0, lat, d0);
        checks++;
        if (out_password !== exp || out_length !== 5'd2 || lat !== 2) begin
            errors++; $display("FAIL b2b_first: got %h len=%0d lat=%0d expected %h len=2 lat=2", out_password, out_length, lat, exp);
        end
        pw = exp;
        exp[159:152] = 8'h21;
        run_req(pw, 5'd2, 0, lat, d0);
        checks++;
        if (out_password !== exp || out_length !== 5'd2 || lat !== 1 || d0 !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got %h len=%0d lat=%0d d0=%b expected %h len=2 lat=1 d0=0", out_password, out_length, lat, d0, exp);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_empty_append();
        test_simple_inc();
        test_carry();
        test_overflow();
        test_length_clamp();
        test_trigger_held();
        test_edge_in_carry();
        test_reset_mid_carry();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
